// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers. It detects load-use hazards and taken branches/jumps, and
//   drives the PC-write, stall and flush controls. A halt in ID starts a
//   drain sequence that lets in-flight instructions retire. After the drain
//   the core stops until Reset.
//
// Optional feature macro:
//   HAZ_PERF_CNT_EN  - adds the saturating StallCnt/FlushCnt performance
//                      counters and their output ports.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN after a halt is accepted (1..7)
//   CNT_W         performance counter width (HAZ_PERF_CNT_EN only)
//
// Ports:
//   Clk          system clock (state updates on rising edge)
//   Reset        synchronous, active-high reset
//   ID_Rs        rs field of the instruction in ID
//   ID_Rt        rt field of the instruction in ID
//   ID_UsesRt    instruction in ID reads rt
//   ID_Halt      instruction in ID is a halt
//   EX_MemRead   instruction in EX is a load
//   EX_RegWre    instruction in EX writes the register file
//   EX_WriteReg  destination register of the instruction in EX
//   EX_Redirect  taken branch/jump resolved in EX
//   PCWre        PC may update
//   IF_ID_Write  IF/ID may load
//   IF_ID_Flush  zero IF/ID
//   ID_EX_Flush  zero ID/EX (bubble)
//   Halted       core stopped
//   StallCnt     load-use stall cycles     (HAZ_PERF_CNT_EN only)
//   FlushCnt     redirect flush events     (HAZ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Halt,
    input  logic             EX_MemRead,
    input  logic             EX_RegWre,
    input  logic [4:0]       EX_WriteReg,
    input  logic             EX_Redirect,
    output logic             PCWre,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Halted
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] drain_cnt_r;
    logic [2:0] drain_cnt_nxt_s;
    logic       lu_s;

    // Load-use hazard: a load in EX targets a register the ID instruction reads.
    // r0 is hard-wired zero, so a load to r0 never needs a stall.
    always_comb begin
        lu_s = 1'b0;
        if (EX_MemRead && EX_RegWre && (EX_WriteReg != 5'd0) &&
            ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)))) begin
            lu_s = 1'b1;
        end else begin
            lu_s = 1'b0;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Next-state and pipeline control outputs (combinational, zero latency).
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        PCWre           = 1'b0;
        IF_ID_Write     = 1'b0;
        IF_ID_Flush     = 1'b1;
        ID_EX_Flush     = 1'b1;
        Halted          = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (EX_Redirect) begin
                    // A halt in ID here is on the wrong path and is dropped.
                    PCWre       = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (lu_s) begin
                    // Hold PC and IF/ID, bubble into EX; a halt retries next cycle.
                    PCWre       = 1'b0;
                    IF_ID_Write = 1'b0;
                    IF_ID_Flush = 1'b0;
                    ID_EX_Flush = 1'b1;
                end else if (ID_Halt) begin
                    // Halt moves into EX as a no-write op; stop fetching.
                    PCWre           = 1'b0;
                    IF_ID_Write     = 1'b1;
                    IF_ID_Flush     = 1'b1;
                    ID_EX_Flush     = 1'b0;
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = DRAIN_LOAD;
                end else begin
                    PCWre       = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b0;
                    ID_EX_Flush = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 3'd0) begin
                    state_nxt_s     = ST_HALTED;
                    drain_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = drain_cnt_r - 3'd1;
                end
            end
            ST_HALTED: begin
                Halted      = 1'b1;
                state_nxt_s = ST_HALTED;
            end
            default: begin
                // Unreachable encoding: recover to RUN with the pipe frozen.
                state_nxt_s     = ST_RUN;
                drain_cnt_nxt_s = 3'd0;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             stall_ev_s;
    logic             flush_ev_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Count events in RUN only; a stall counts only when it wins priority.
    always_comb begin
        stall_ev_s = 1'b0;
        flush_ev_s = 1'b0;
        if (state_r == ST_RUN) begin
            flush_ev_s = EX_Redirect;
            stall_ev_s = lu_s && !EX_Redirect;
        end else begin
            flush_ev_s = 1'b0;
            stall_ev_s = 1'b0;
        end
    end

    // Saturating performance counters, cleared only by Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_ev_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed testbench for pipeline_hazard_ctrl with DRAIN_CYCLES=3. The
// control outputs are compared as the packed vector
// {PCWre, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Halted}.
// Counter checks are compiled in only when HAZ_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        ID_Halt;
    logic        EX_MemRead;
    logic        EX_RegWre;
    logic [4:0]  EX_WriteReg;
    logic        EX_Redirect;
    logic        PCWre;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        Halted;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] StallCnt;
    logic [15:0] FlushCnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [4:0] ctrl_s;
    assign ctrl_s = {PCWre, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Halted};

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES(3),
        .CNT_W(16)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .ID_Rs(ID_Rs),
        .ID_Rt(ID_Rt),
        .ID_UsesRt(ID_UsesRt),
        .ID_Halt(ID_Halt),
        .EX_MemRead(EX_MemRead),
        .EX_RegWre(EX_RegWre),
        .EX_WriteReg(EX_WriteReg),
        .EX_Redirect(EX_Redirect),
        .PCWre(PCWre),
        .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush),
        .Halted(Halted)
`ifdef HAZ_PERF_CNT_EN
        ,
        .StallCnt(StallCnt),
        .FlushCnt(FlushCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected control vectors {PCWre, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Halted}
    localparam logic [4:0] C_RUN    = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_REDIR  = 5'b11110;
    localparam logic [4:0] C_HALTIN = 5'b01100;
    localparam logic [4:0] C_DRAIN  = 5'b00110;
    localparam logic [4:0] C_HALTED = 5'b00111;

    task automatic set_idle();
        ID_Rs       = 5'd0;
        ID_Rt       = 5'd0;
        ID_UsesRt   = 1'b0;
        ID_Halt     = 1'b0;
        EX_MemRead  = 1'b0;
        EX_RegWre   = 1'b0;
        EX_WriteReg = 5'd0;
        EX_Redirect = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL reset_ctrl got %b expected %b", ctrl_s, C_RUN);
        end
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if ({StallCnt, FlushCnt} !== 32'h0000_0000) begin
            n_fails++;
            $display("FAIL reset_counters got %h/%h expected 0/0", StallCnt, FlushCnt);
        end
`endif
    endtask

    task automatic test_load_use_rs();
        // Load r5 in EX, ID reads r5 via rs -> one stall cycle.
        EX_MemRead = 1'b1; EX_RegWre = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
        #2;
        n_checks++;
        if (ctrl_s !== C_STALL) begin
            n_fails++;
            $display("FAIL lu_rs_stall got %b expected %b", ctrl_s, C_STALL);
        end
        next_cycle();
        // Load has moved to MEM; EX now holds a non-load.
        EX_MemRead = 1'b0; EX_RegWre = 1'b0;
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL lu_release got %b expected %b", ctrl_s, C_RUN);
        end
        next_cycle();
        // Load to r0 never stalls.
        EX_MemRead = 1'b1; EX_RegWre = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0;
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL lu_r0 got %b expected %b", ctrl_s, C_RUN);
        end
        next_cycle();
        // Load without register write enabled is not a hazard.
        EX_RegWre = 1'b0; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL lu_noregwre got %b expected %b", ctrl_s, C_RUN);
        end
        next_cycle();
        set_idle();
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if (StallCnt !== 16'd1) begin
            n_fails++;
            $display("FAIL stallcnt_1 got %0d expected 1", StallCnt);
        end
`endif
    endtask

    task automatic test_load_use_rt();
        EX_MemRead = 1'b1; EX_RegWre = 1'b1; EX_WriteReg = 5'd5;
        ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 1'b0;
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL lu_rt_unused got %b expected %b", ctrl_s, C_RUN);
        end
        next_cycle();
        ID_UsesRt = 1'b1;
        #2;
        n_checks++;
        if (ctrl_s !== C_STALL) begin
            n_fails++;
            $display("FAIL lu_rt_used got %b expected %b", ctrl_s, C_STALL);
        end
        next_cycle();
        set_idle();
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if (StallCnt !== 16'd2) begin
            n_fails++;
            $display("FAIL stallcnt_2 got %0d expected 2", StallCnt);
        end
`endif
    endtask

    task automatic test_redirect_priority();
        // Redirect + load-use + halt together: redirect wins, halt dropped.
        EX_Redirect = 1'b1; ID_Halt = 1'b1;
        EX_MemRead = 1'b1; EX_RegWre = 1'b1; EX_WriteReg = 5'd7; ID_Rs = 5'd7;
        #2;
        n_checks++;
        if (ctrl_s !== C_REDIR) begin
            n_fails++;
            $display("FAIL redirect_prio got %b expected %b", ctrl_s, C_REDIR);
        end
        next_cycle();
        set_idle();
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL redirect_stays_run got %b expected %b", ctrl_s, C_RUN);
        end
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if ({StallCnt, FlushCnt} !== {16'd2, 16'd1}) begin
            n_fails++;
            $display("FAIL redirect_counters got %0d/%0d expected 2/1", StallCnt, FlushCnt);
        end
`endif
        next_cycle();
    endtask

    task automatic test_halt_drain();
        ID_Halt = 1'b1;
        #2;
        n_checks++;
        if (ctrl_s !== C_HALTIN) begin
            n_fails++;
            $display("FAIL halt_accept got %b expected %b", ctrl_s, C_HALTIN);
        end
        next_cycle();
        ID_Halt = 1'b0;
        // Hazard and redirect inputs present during DRAIN must be ignored.
        EX_Redirect = 1'b1;
        EX_MemRead = 1'b1; EX_RegWre = 1'b1; EX_WriteReg = 5'd9; ID_Rs = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (ctrl_s !== C_DRAIN) begin
                n_fails++;
                $display("FAIL drain_cycle%0d got %b expected %b", i, ctrl_s, C_DRAIN);
            end
            next_cycle();
        end
        for (int i = 0; i < 10; i++) begin
            #2;
            n_checks++;
            if (ctrl_s !== C_HALTED) begin
                n_fails++;
                $display("FAIL halted_cycle%0d got %b expected %b", i, ctrl_s, C_HALTED);
            end
            next_cycle();
        end
`ifdef HAZ_PERF_CNT_EN
        n_checks++;
        if ({StallCnt, FlushCnt} !== {16'd2, 16'd1}) begin
            n_fails++;
            $display("FAIL drain_counters got %0d/%0d expected 2/1", StallCnt, FlushCnt);
        end
`endif
        set_idle();
        // Reset leaves HALTED.
        do_reset();
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL reset_from_halted got %b expected %b", ctrl_s, C_RUN);
        end
    endtask

    task automatic test_reset_mid_drain();
        ID_Halt = 1'b1;
        next_cycle();
        ID_Halt = 1'b0;
        next_cycle();
        // Second DRAIN cycle: still draining until the reset edge.
        #2;
        n_checks++;
        if (ctrl_s !== C_DRAIN) begin
            n_fails++;
            $display("FAIL drain2_before_reset got %b expected %b", ctrl_s, C_DRAIN);
        end
        Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
        #2;
        n_checks++;
        if (ctrl_s !== C_RUN) begin
            n_fails++;
            $display("FAIL reset_mid_drain got %b expected %b", ctrl_s, C_RUN);
        end
        next_cycle();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_flush_saturate();
        do_reset();
        EX_Redirect = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(posedge Clk);
        end
        #1;
        n_checks++;
        if (FlushCnt !== 16'hFFFE) begin
            n_fails++;
            $display("FAIL flushcnt_pre_sat got %h expected fffe", FlushCnt);
        end
        for (int i = 0; i < 70000 - 65534; i++) begin
            @(posedge Clk);
        end
        #1;
        n_checks++;
        if (FlushCnt !== 16'hFFFF) begin
            n_fails++;
            $display("FAIL flushcnt_sat got %h expected ffff", FlushCnt);
        end
        set_idle();
    endtask
`endif

    initial begin
        Reset = 1'b0;
        set_idle();
        test_reset();
        test_load_use_rs();
        test_load_use_rt();
        test_redirect_priority();
        test_halt_drain();
        test_reset_mid_drain();
`ifdef HAZ_PERF_CNT_EN
        test_flush_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
